// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: a round-robin arbiter picks one request,
// latches its operands, computes the result in a single EXEC cycle and holds
// it in DONE until the consumer accepts it.
module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic         rdy,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] S,
  output logic         Ov,
  output logic         valid,
  output logic         id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;   // requester served most recently
  logic           win_q, win_d;     // owner of the operation in flight
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  op_e            op_q, op_d;
  logic [W-1:0]   s_q, s_d;
  logic           ov_q, ov_d;
  logic           valid_q, valid_d;
  logic           id_q, id_d;

  logic           pick;             // arbitration winner this cycle
  logic [W-1:0]   sum, diff, res;
  logic           res_ov;

  // With contention the requester not served last wins; otherwise the lone requester wins.
  assign pick = (req0 && req1) ? ~last_q : req1;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Result and signed overflow of the latched operation.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    res    = '0;
    res_ov = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res    = sum;
        res_ov = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        res    = diff;
        res_ov = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
    endcase
  end

  // Next-state and next-value logic for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s_d     = s_q;
    ov_d    = ov_q;
    valid_d = valid_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = EXEC;
          last_d  = pick;
          win_d   = pick;
          a_d     = pick ? A1 : A0;
          b_d     = pick ? B1 : B0;
          op_d    = op_e'(pick ? op1 : op0);
        end
      end
      EXEC: begin
        state_d = DONE;
        s_d     = res;
        ov_d    = res_ov;
        id_d    = win_q;
        valid_d = 1'b1;
      end
      DONE: begin
        if (rdy) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      s_q     <= '0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      s_q     <= s_d;
      ov_q    <= ov_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  // Operand latch, written only on the IDLE->EXEC edge.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are deliberately left without reset; they are
    // always loaded before being consumed, so a reset would only cost logic.
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign gnt0  = (state_q == EXEC) && !win_q;
  assign gnt1  = (state_q == EXEC) &&  win_q;
  assign busy  = (state_q != IDLE);
  assign S     = s_q;
  assign Ov    = ov_q;
  assign valid = valid_q;
  assign id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single operations on each requester,
// round-robin contention, result hold under back-pressure and mid-flight reset.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] A0, B0, A1, B1;
  logic [1:0] op0, op1;
  logic       rdy;
  logic       gnt0, gnt1;
  logic [3:0] S;
  logic       Ov, valid, id, busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .A0    (A0),
    .B0    (B0),
    .A1    (A1),
    .B1    (B1),
    .op0   (op0),
    .op1   (op1),
    .rdy   (rdy),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .S     (S),
    .Ov    (Ov),
    .valid (valid),
    .id    (id),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One uncontended operation from requester sel, accepted immediately.
  // Operands are scrambled during EXEC to show they were latched.
  task automatic do_op(input string tag, input logic sel, input logic [3:0] a,
                       input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] exp_s, input logic exp_ov);
    if (sel) begin
      req1 = 1'b1; A1 = a; B1 = b; op1 = op;
    end else begin
      req0 = 1'b1; A0 = a; B0 = b; op0 = op;
    end
    rdy = 1'b1;
    tick();
    check1({tag, ".gnt0"}, gnt0, !sel);
    check1({tag, ".gnt1"}, gnt1, sel);
    check1({tag, ".busy_exec"}, busy, 1'b1);
    check1({tag, ".valid_exec"}, valid, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    A0 = ~a; B0 = ~b; op0 = ~op;
    A1 = ~a; B1 = ~b; op1 = ~op;
    tick();
    check4({tag, ".S"}, S, exp_s);
    check1({tag, ".Ov"}, Ov, exp_ov);
    check1({tag, ".id"}, id, sel);
    check1({tag, ".valid"}, valid, 1'b1);
    check1({tag, ".gnt_done"}, gnt0 | gnt1, 1'b0);
    tick();
    check1({tag, ".valid_clr"}, valid, 1'b0);
    check1({tag, ".busy_idle"}, busy, 1'b0);
    check4({tag, ".S_hold"}, S, exp_s);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rdy = 1'b0;
    A0 = 4'h0; B0 = 4'h0; A1 = 4'h0; B1 = 4'h0; op0 = 2'b00; op1 = 2'b00;
    tick();
    tick();

    // Reset state.
    check1("rst.valid", valid, 1'b0);
    check1("rst.busy", busy, 1'b0);
    check4("rst.S", S, 4'b0000);
    check1("rst.Ov", Ov, 1'b0);
    check1("rst.id", id, 1'b0);
    check1("rst.gnt0", gnt0, 1'b0);
    check1("rst.gnt1", gnt1, 1'b0);
    rst = 1'b0;

    // Add, sub, AND, OR with hand-computed results.
    do_op("add_ovf", 1'b0, 4'b0111, 4'b0001, 2'b00, 4'b1000, 1'b1);
    do_op("sub_neg", 1'b1, 4'b0011, 4'b0101, 2'b01, 4'b1110, 1'b0);
    do_op("sub_ovf", 1'b1, 4'b1000, 4'b0001, 2'b01, 4'b0111, 1'b1);
    do_op("and",     1'b0, 4'b1100, 4'b1010, 2'b10, 4'b1000, 1'b0);
    do_op("or",      1'b0, 4'b1100, 4'b1010, 2'b11, 4'b1110, 1'b0);
    do_op("add_ok",  1'b1, 4'b0011, 4'b0100, 2'b00, 4'b0111, 1'b0);
    do_op("add_nov", 1'b1, 4'b1000, 4'b1000, 2'b00, 4'b0000, 1'b1);

    // Back-pressure: result held in DONE while rdy=0 and inputs change.
    req0 = 1'b1; A0 = 4'b0010; B0 = 4'b0011; op0 = 2'b00; rdy = 1'b0;
    tick();
    check1("hold.gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    tick();
    check4("hold.S0", S, 4'b0101);
    check1("hold.valid0", valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      A0 = A0 + 4'd3; B0 = ~B0; op0 = op0 + 2'd1;
      req0 = 1'b1; req1 = 1'b1;
      tick();
      check1("hold.valid", valid, 1'b1);
      check4("hold.S", S, 4'b0101);
      check1("hold.Ov", Ov, 1'b0);
      check1("hold.id", id, 1'b0);
      check1("hold.busy", busy, 1'b1);
      check1("hold.gnt", gnt0 | gnt1, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0; rdy = 1'b1;
    tick();
    check1("hold.release_valid", valid, 1'b0);
    check1("hold.release_busy", busy, 1'b0);

    // Round-robin contention right after reset: grants 0,1,0,1 every 3 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    A0 = 4'b0001; B0 = 4'b0001; op0 = 2'b00;
    A1 = 4'b0110; B1 = 4'b0010; op1 = 2'b01;
    req0 = 1'b1; req1 = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check1("rr.gnt0", gnt0, (k % 6) == 0);
      check1("rr.gnt1", gnt1, (k % 6) == 3);
      check1("rr.excl", gnt0 & gnt1, 1'b0);
      if ((k % 3) == 1) begin
        check1("rr.id", id, (k % 6) == 4);
        check4("rr.S", S, ((k % 6) == 4) ? 4'b0100 : 4'b0010);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check1("rr.idle", busy, 1'b0);

    // Reset during EXEC: pointer is at "0 served last", so contention picks 1.
    do_op("pre_exec", 1'b0, 4'b0010, 4'b0011, 2'b00, 4'b0101, 1'b0);
    req0 = 1'b1; req1 = 1'b1; A1 = 4'b0001; B1 = 4'b0001; op1 = 2'b00;
    A0 = 4'b0011; B0 = 4'b0100; op0 = 2'b00;
    tick();
    check1("rexec.gnt1", gnt1, 1'b1);
    rst = 1'b1;
    tick();
    check1("rexec.valid", valid, 1'b0);
    check1("rexec.gnt", gnt0 | gnt1, 1'b0);
    check1("rexec.busy", busy, 1'b0);
    check4("rexec.S", S, 4'b0000);
    rst = 1'b0;
    tick();
    check1("rexec.next_gnt0", gnt0, 1'b1);
    check1("rexec.next_gnt1", gnt1, 1'b0);

    // Reset during DONE of a requester-0 result; next contention still goes to 0.
    rdy = 1'b0;
    tick();
    check1("rdone.valid_pre", valid, 1'b1);
    check4("rdone.S_pre", S, 4'b0111);
    rst = 1'b1;
    tick();
    check1("rdone.valid", valid, 1'b0);
    check1("rdone.gnt", gnt0 | gnt1, 1'b0);
    check1("rdone.busy", busy, 1'b0);
    check4("rdone.S", S, 4'b0000);
    check1("rdone.Ov", Ov, 1'b0);
    check1("rdone.id", id, 1'b0);
    rst = 1'b0;
    tick();
    check1("rdone.next_gnt0", gnt0, 1'b1);
    check1("rdone.next_gnt1", gnt1, 1'b0);
    req0 = 1'b0; req1 = 1'b0; rdy = 1'b1;
    tick();
    check1("rdone.final_valid", valid, 1'b1);
    tick();
    check1("rdone.final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
